// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: drains UART receiver frames/breaks into a FIFO stream and applies config between frames.
// Define UART_RX_IDLE_TIMEOUT_EN to add the idle_chars input and a character-time idle interrupt.
module uart_rx_ctrl #(
    parameter int CLOCK_DIVISOR_WIDTH = 24,
    parameter int FIFO_DEPTH          = 16,
    parameter int FRAME_BITS_MAX      = 13
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_wr,
    input  logic [1:0]                     cfg_data_bits,
    input  logic                           cfg_has_parity,
    input  logic [1:0]                     cfg_parity_mode,
    input  logic                           cfg_extra_stop,
    input  logic [CLOCK_DIVISOR_WIDTH-1:0] cfg_divisor,
    output logic                           cfg_pending,
    input  logic                           rx_line,
    output logic [1:0]                     rx_data_bits,
    output logic                           rx_has_parity,
    output logic [1:0]                     rx_parity_mode,
    output logic                           rx_extra_stop,
    output logic [CLOCK_DIVISOR_WIDTH-1:0] rx_divisor,
    input  logic [8:0]                     rx_data,
    input  logic                           rx_data_received,
    input  logic                           rx_parity_error,
    input  logic                           rx_overflow,
    input  logic                           rx_break,
    output logic                           rx_receive_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [11:0]                    m_data,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           overrun,
    input  logic                           overrun_clr,
`ifdef UART_RX_IDLE_TIMEOUT_EN
    input  logic [3:0]                     idle_chars,
`endif
    output logic                           irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(FRAME_BITS_MAX + 1);
    localparam int CW = CLOCK_DIVISOR_WIDTH + 6;
    localparam logic [CW-1:0] CFG_RST = {2'd3, {(CW-2){1'b0}}};

    typedef enum logic {LINE_IDLE, LINE_BUSY} line_e;
    typedef enum logic [1:0] {CFG_IDLE, CFG_PENDING, CFG_APPLY} cfg_e;

    logic [1:0]                     sync_q;
    logic                           rx_s;
    line_e                          line_q, line_d;
    logic [CLOCK_DIVISOR_WIDTH-1:0] div_q, div_d;
    logic [BW-1:0]                  bit_q, bit_d;
    logic                           line_idle;
    cfg_e                           cfg_q, cfg_d;
    logic                           apply;
    logic [CW-1:0]                  sh_q, act_q;
    logic                           ack_q, brk_q, rcv_q, cap, push, pop, full, drop;
    logic [11:0]                    din, head_d, m_data_q;
    logic [11:0]                    mem [FIFO_DEPTH];
    logic [AW-1:0]                  wr_q, rd_q, rd_d;
    logic [LW-1:0]                  cnt_q, cnt_d;
    logic                           m_valid_q, overrun_q, overrun_d, irq_q, irq_d;

    assign rx_s = sync_q[1];
    assign {rx_data_bits, rx_has_parity, rx_parity_mode, rx_extra_stop, rx_divisor} = act_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            line_q <= LINE_IDLE;
            div_q  <= '0;
            bit_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], rx_line};
            line_q <= line_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
        end
    end

    // Bit-period timeout guards against a start edge that never yields a frame event
    always_comb begin
        line_d = line_q;
        div_d  = '0;
        bit_d  = '0;
        if (line_q == LINE_IDLE) begin
            line_d = rx_s ? LINE_IDLE : LINE_BUSY;
        end else if (cap || bit_q == BW'(FRAME_BITS_MAX)) begin
            line_d = LINE_IDLE;
        end else begin
            div_d = (div_q == rx_divisor) ? '0 : div_q + 1'b1;
            bit_d = (div_q == rx_divisor) ? bit_q + 1'b1 : bit_q;
        end
    end

    always_comb begin
        line_idle = line_q == LINE_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= CFG_IDLE;
            sh_q  <= CFG_RST;
            act_q <= CFG_RST;
        end else begin
            cfg_q <= cfg_d;
            if (cfg_wr) sh_q <= {cfg_data_bits, cfg_has_parity, cfg_parity_mode, cfg_extra_stop, cfg_divisor};
            if (apply) act_q <= sh_q;
        end
    end

    always_comb begin
        cfg_d = cfg_q;
        if (cfg_q == CFG_PENDING) cfg_d = (line_idle && rx_s) ? CFG_APPLY : CFG_PENDING;
        else cfg_d = cfg_wr ? CFG_PENDING : CFG_IDLE;
    end

    always_comb begin
        cfg_pending = cfg_q == CFG_PENDING;
        apply       = cfg_q == CFG_APPLY;
    end

    // A break arriving with a frame is folded into that frame's entry
    assign cap       = ~ack_q & (rx_data_received | (rx_break & ~brk_q));
    assign din       = rx_data_received ? {rx_break, rx_overflow, rx_parity_error, rx_data} : 12'h800;
    assign pop       = m_valid_q & m_ready;
    assign full      = cnt_q == LW'(FIFO_DEPTH);
    assign push      = cap & (~full | pop);
    assign drop      = cap & ~push;
    assign cnt_d     = cnt_q + LW'(push) - LW'(pop);
    assign rd_d      = rd_q + AW'(pop);
    assign head_d    = (push && cnt_q == LW'(pop)) ? din : (cnt_d != '0 ? mem[rd_d] : m_data_q);
    assign overrun_d = drop | (overrun_q & ~overrun_clr);

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q     <= 1'b0;
            brk_q     <= 1'b0;
            rcv_q     <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= cap | (ack_q & (rx_data_received | rx_break));
            brk_q     <= rx_break;
            rcv_q     <= cap;
            wr_q      <= wr_q + AW'(push);
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            m_valid_q <= cnt_d != '0;
            m_data_q  <= head_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

`ifdef UART_RX_IDLE_TIMEOUT_EN
    logic [CLOCK_DIVISOR_WIDTH-1:0] idiv_q, idiv_d;
    logic [BW-1:0]                  ibit_q, ibit_d;
    logic [3:0]                     chr_q, chr_d;
    logic                           char_end;

    assign char_end = idiv_q == rx_divisor && ibit_q == BW'(FRAME_BITS_MAX - 1);

    // Counts whole character times of silence while data waits; saturates at the threshold
    always_comb begin
        idiv_d = '0;
        ibit_d = '0;
        chr_d  = '0;
        if (line_idle && cnt_q != '0 && !push && !pop) begin
            idiv_d = (idiv_q == rx_divisor) ? '0 : idiv_q + 1'b1;
            ibit_d = char_end ? '0 : (idiv_q == rx_divisor) ? ibit_q + 1'b1 : ibit_q;
            chr_d  = (char_end && chr_q < idle_chars) ? chr_q + 1'b1 : chr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idiv_q <= '0;
            ibit_q <= '0;
            chr_q  <= '0;
        end else begin
            idiv_q <= idiv_d;
            ibit_q <= ibit_d;
            chr_q  <= chr_d;
        end
    end

    assign irq_d = overrun_d | (cnt_d >= LW'(FIFO_DEPTH / 2)) | (idle_chars != 4'd0 && chr_d == idle_chars);
`else
    assign irq_d = (cnt_d != '0) | overrun_d;
`endif

    assign rx_receive_data = rcv_q;
    assign m_valid         = m_valid_q;
    assign m_data          = m_data_q;
    assign fifo_level      = cnt_q;
    assign overrun         = overrun_q;
    assign irq             = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl; stimulus queues expected FIFO entries, a monitor checks pops.
module tb_uart_rx_ctrl;
    localparam int CDW = 24;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_wr = 1'b0;
    logic [1:0]      cfg_data_bits = '0;
    logic            cfg_has_parity = 1'b0;
    logic [1:0]      cfg_parity_mode = '0;
    logic            cfg_extra_stop = 1'b0;
    logic [CDW-1:0]  cfg_divisor = '0;
    logic            cfg_pending;
    logic            rx_line = 1'b1;
    logic [1:0]      rx_data_bits;
    logic            rx_has_parity;
    logic [1:0]      rx_parity_mode;
    logic            rx_extra_stop;
    logic [CDW-1:0]  rx_divisor;
    logic [8:0]      rx_data = '0;
    logic            rx_data_received = 1'b0;
    logic            rx_parity_error = 1'b0;
    logic            rx_overflow = 1'b0;
    logic            rx_break = 1'b0;
    logic            rx_receive_data;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [11:0]     m_data;
    logic [4:0]      fifo_level;
    logic            overrun;
    logic            overrun_clr = 1'b0;
    logic            irq;

    int          checks = 0;
    int          failures = 0;
    int          ack_cnt = 0;
    int          ack_base;
    logic [11:0] exp_q[$];
    logic [11:0] exp_head;

    uart_rx_ctrl #(.CLOCK_DIVISOR_WIDTH(CDW), .FIFO_DEPTH(DEPTH), .FRAME_BITS_MAX(13)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr(cfg_wr), .cfg_data_bits(cfg_data_bits), .cfg_has_parity(cfg_has_parity),
        .cfg_parity_mode(cfg_parity_mode), .cfg_extra_stop(cfg_extra_stop), .cfg_divisor(cfg_divisor),
        .cfg_pending(cfg_pending), .rx_line(rx_line),
        .rx_data_bits(rx_data_bits), .rx_has_parity(rx_has_parity), .rx_parity_mode(rx_parity_mode),
        .rx_extra_stop(rx_extra_stop), .rx_divisor(rx_divisor),
        .rx_data(rx_data), .rx_data_received(rx_data_received), .rx_parity_error(rx_parity_error),
        .rx_overflow(rx_overflow), .rx_break(rx_break), .rx_receive_data(rx_receive_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .fifo_level(fifo_level),
        .overrun(overrun), .overrun_clr(overrun_clr),
`ifdef UART_RX_IDLE_TIMEOUT_EN
        .idle_chars(4'd0),
`endif
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Monitor: every negedge with valid & ready is exactly one pop at the next posedge
    always @(negedge clk) begin
        if (rx_receive_data) ack_cnt++;
        if (rst_n && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected got=%h exp=none", m_data);
            end else begin
                exp_head = exp_q.pop_front();
                if (m_data !== exp_head) begin
                    failures++;
                    $display("FAIL pop_data got=%h exp=%h", m_data, exp_head);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [8:0] d, input logic pe, input logic ov, input logic bk, input logic keep);
        rx_data = d;
        rx_parity_error = pe;
        rx_overflow = ov;
        rx_break = bk;
        rx_data_received = 1'b1;
        if (keep) exp_q.push_back({bk, ov, pe, d});
        step(2);
        {rx_data_received, rx_break, rx_overflow, rx_parity_error} = 4'b0;
        step(1);
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        for (int i = 0; i < 40 && fifo_level != 0; i++) step(1);
        m_ready = 1'b0;
        chk({name, "_level"}, 32'(fifo_level), 0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
        chk({name, "_irq"}, 32'(irq), 0);
    endtask

    task automatic cfg(input logic [1:0] db, input logic hp, input logic [1:0] pm, input logic es, input logic [CDW-1:0] dv);
        {cfg_data_bits, cfg_has_parity, cfg_parity_mode, cfg_extra_stop, cfg_divisor} = {db, hp, pm, es, dv};
        cfg_wr = 1'b1;
        step(1);
        cfg_wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        step(2);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_ack", 32'(rx_receive_data), 0);
        chk("rst_pending", 32'(cfg_pending), 0);
        chk("rst_cfg", {rx_data_bits, rx_has_parity, rx_parity_mode, rx_extra_stop}, 32'b11_0_00_0);
        chk("rst_div", 32'(rx_divisor), 0);
        rst_n = 1'b1;
        step(2);

        // First frame: single clear pulse even though dataReceived is held two cycles
        rx_data = 9'h0A5;
        rx_data_received = 1'b1;
        exp_q.push_back(12'h0A5);
        step(1);
        chk("f1_ack", 32'(rx_receive_data), 1);
        chk("f1_valid", 32'(m_valid), 1);
        chk("f1_data", 32'(m_data), 32'h0A5);
        chk("f1_level", 32'(fifo_level), 1);
        chk("f1_irq", 32'(irq), 1);
        step(1);
        chk("f1_ack_single", 32'(rx_receive_data), 0);
        chk("f1_no_dup", 32'(fifo_level), 1);
        rx_data_received = 1'b0;
        step(1);

        rx_break = 1'b1;
        exp_q.push_back(12'h800);
        step(2);
        rx_break = 1'b0;
        step(1);
        chk("brk_level", 32'(fifo_level), 2);
        frame(9'h055, 1'b0, 1'b1, 1'b0, 1'b1);
        frame(9'h1FF, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("mix_level", 32'(fifo_level), 4);
        chk("head_unchanged", 32'(m_data), 32'h0A5);
        drain("d1");

        // Overflow: 17 frames into 16 entries
        ack_base = ack_cnt;
        for (int i = 0; i < 17; i++) frame(9'(9'h100 + i), 1'b0, 1'b0, 1'b0, i < 16);
        chk("ovf_level", 32'(fifo_level), 16);
        chk("ovf_overrun", 32'(overrun), 1);
        chk("ovf_irq", 32'(irq), 1);
        chk("ovf_acks", ack_cnt - ack_base, 17);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        chk("ovf_clr", 32'(overrun), 0);

        // Drop in the same cycle as a clear: overrun must stay set
        rx_data = 9'h077;
        rx_data_received = 1'b1;
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        chk("clr_vs_drop", 32'(overrun), 1);
        step(1);
        rx_data_received = 1'b0;
        step(1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        chk("ovf_clr2", 32'(overrun), 0);

        // Full FIFO, simultaneous pop and push: push accepted
        m_ready = 1'b1;
        rx_data = 9'h0AA;
        rx_data_received = 1'b1;
        exp_q.push_back(12'h0AA);
        step(1);
        m_ready = 1'b0;
        chk("full_pp_level", 32'(fifo_level), 16);
        chk("full_pp_overrun", 32'(overrun), 0);
        step(1);
        rx_data_received = 1'b0;
        step(1);
        chk("full_pp_hold", 32'(fifo_level), 16);
        drain("d2");

        // Config applies promptly while the line is idle
        cfg(2'd1, 1'b1, 2'b10, 1'b1, 24'd100);
        chk("cfg_pend_idle", 32'(cfg_pending), 1);
        step(3);
        chk("cfg_div100", 32'(rx_divisor), 100);
        chk("cfg_fields", {rx_data_bits, rx_has_parity, rx_parity_mode, rx_extra_stop}, 32'b01_1_10_1);
        chk("cfg_pend_clr", 32'(cfg_pending), 0);

        // Busy line holds the request until a frame capture
        rx_line = 1'b0;
        step(4);
        cfg(2'd3, 1'b0, 2'b00, 1'b0, 24'd7);
        step(50);
        chk("busy_pending", 32'(cfg_pending), 1);
        chk("busy_div_hold", 32'(rx_divisor), 100);
        rx_line = 1'b1;
        step(20);
        chk("busy_until_cap", 32'(cfg_pending), 1);
        frame(9'h033, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4);
        chk("cap_applied", 32'(rx_divisor), 7);
        chk("cap_pend_clr", 32'(cfg_pending), 0);

        // Start glitch with no frame: held until 13*(7+1) cycle timeout
        rx_line = 1'b0;
        step(3);
        rx_line = 1'b1;
        cfg(2'd2, 1'b0, 2'b00, 1'b0, 24'd3);
        step(80);
        chk("to_pending", 32'(cfg_pending), 1);
        chk("to_div_hold", 32'(rx_divisor), 7);
        step(30);
        chk("to_applied", 32'(rx_divisor), 3);
        chk("to_pend_clr", 32'(cfg_pending), 0);

        // Write landing in the apply cycle: old shadow applied, new one pending
        cfg(2'd3, 1'b0, 2'b00, 1'b0, 24'd11);
        step(1);
        cfg(2'd3, 1'b0, 2'b00, 1'b0, 24'd12);
        chk("apply_wr_div", 32'(rx_divisor), 11);
        chk("apply_wr_pend", 32'(cfg_pending), 1);
        step(3);
        chk("apply_wr_final", 32'(rx_divisor), 12);
        chk("apply_wr_clr", 32'(cfg_pending), 0);

        drain("d3");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
